if_id_stage: RTL and testbench
==============================

# if_id_stage

Instruction-fetch stage and IF/ID pipeline register of the MIPS pipeline, sitting directly downstream of the hazard detection unit. It owns the PC, drives the instruction-memory address, and latches each fetched instruction with its PC+4 into the IF/ID register. It obeys the hazard unit's `pc_ld`, `IF_ID_reg_ld`, `flush` and `is_jmp` outputs. It computes the redirect target for taken branches and jumps from the instruction currently held in IF/ID.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `CNT_W`, default 16: width of the performance counters; used only with `IF_PERF_CNT_EN`.

- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous and active-low.
- `pc_ld`  in  1: PC load enable from the hazard unit; 0 means stall.
- `IF_ID_reg_ld`  in  1: IF/ID register load enable from the hazard unit.
- `flush`  in  1: taken branch or jump in ID; redirect the PC and bubble IF/ID.
- `is_jmp`  in  1: the redirect is a jump. When 0 with `flush`=1, it is a taken branch.
- `imem_data`  in  32: instruction read combinationally at `imem_addr`.
- `imem_addr`  out  32: current PC.
- `ID_inst`  out  32: IF/ID instruction.
- `ID_pc4`  out  32: IF/ID PC+4.
- `ID_valid`  out  1: 1 = real instruction, 0 = bubble.
- `stall_cnt`  out  CNT_W: cycles with `pc_ld`=0 (only with `IF_PERF_CNT_EN`).
- `flush_cnt`  out  CNT_W: redirects taken (only with `IF_PERF_CNT_EN`).

## Operation
- PC register drives `imem_addr`. `pc4` = PC + 4, a 32-bit add that wraps modulo 2^32.
- Branch target = `ID_pc4` + ({{14{ID_inst[15]}}, ID_inst[15:0], 2'b00}). This is a 32-bit add and wraps.
- Jump target = {`ID_pc4`[31:28], `ID_inst`[25:0], 2'b00}.
- Next-PC selection, in priority order:
  1. `rst`=0: PC <= RESET_PC.
  2. `pc_ld`=0: PC holds.
  3. `flush`=1: PC <= jump target if `is_jmp`, else branch target.
  4. Otherwise: PC <= pc4.
- IF/ID update, in priority order:
  1. `rst`=0: `ID_inst`, `ID_pc4` <= 0 and `ID_valid` <= 0.
  2. `IF_ID_reg_ld`=0: all three hold.
  3. `flush`=1: `ID_inst` <= 32'h0 (NOP), `ID_pc4` <= pc4, `ID_valid` <= 0.
  4. Otherwise: `ID_inst` <= `imem_data`, `ID_pc4` <= pc4, `ID_valid` <= 1.
- Stall dominates flush. The hazard unit can raise load-use stall and flush in the same cycle. The branch then stays in ID and re-resolves next cycle with correct operands, so no redirect happens during a stall.
- `pc_ld` and `IF_ID_reg_ld` are treated independently. If they differ, each register follows its own enable.
- The block is a two-state machine on `ID_valid`: BUBBLE (0) and VALID (1).
  - BUBBLE -> VALID on a normal load.
  - VALID -> BUBBLE on flush.
  - Both states hold on stall.
  - Reset enters BUBBLE.

## Timing
- `imem_addr` changes only at the clock edge. `imem_data` is sampled the same cycle.
- Fetch-to-ID latency is 1 cycle: an instruction at PC in cycle n appears on `ID_inst` in cycle n+1.
- Redirect penalty is 1 bubble. With `flush` in cycle n, the target is on `imem_addr` in cycle n+1, and its instruction is in ID in cycle n+2.
- Stall of k cycles: PC and IF/ID frozen for exactly k edges, with no instruction lost or duplicated.
- Reset mid-stall or mid-flush: reset wins on the same edge. All outputs take reset values the cycle after `rst` is sampled low.
- Reset values: `imem_addr`=RESET_PC, `ID_inst`=0, `ID_pc4`=0, `ID_valid`=0, `stall_cnt`=0, `flush_cnt`=0.

## Configuration
- `IF_PERF_CNT_EN` defined:
  - `stall_cnt` increments on every cycle with `pc_ld`=0.
  - `flush_cnt` increments on every cycle with `pc_ld`=1 and `flush`=1.
  - Both saturate at 2^CNT_W−1 and clear on reset.
- `IF_PERF_CNT_EN` undefined: counter registers are not built, and `stall_cnt` and `flush_cnt` are tied to 0.

## Test plan
- Reset then 3 free-running cycles with `pc_ld`=`IF_ID_reg_ld`=1 and `flush`=0 -> `imem_addr` 0, 4, 8, 12. `ID_pc4` 4, 8, 12 with `ID_valid`=1 after the first load.
- `pc_ld`=`IF_ID_reg_ld`=0 for 2 cycles with PC=8 -> `imem_addr` stays 8 and `ID_inst` is unchanged. With the macro, `stall_cnt`=2.
- `ID_inst`=beq with imm 16'hFFFE, `ID_pc4`=16, `flush`=1, `is_jmp`=0 -> next `imem_addr`=8, `ID_inst`=0, `ID_valid`=0.
- `ID_inst`=32'h0800_0040 (j), `ID_pc4`=32'h1000_0010, `flush`=`is_jmp`=1 -> next `imem_addr`=32'h1000_0100.
- `flush`=1 and `pc_ld`=`IF_ID_reg_ld`=0 together -> PC and IF/ID hold, and `flush_cnt` does not increment. Next cycle with `pc_ld`=1, the redirect occurs.
- PC=32'hFFFF_FFFC with no stall -> next `imem_addr`=0. `rst`=0 asserted during a stall -> outputs return to reset values on the next edge.

Source files
------------

// File: rtl/if_id_stage_if.sv
// Hazard-unit / instruction-memory / ID-side signal bundle for if_id_stage.
// master: hazard unit + instruction memory side; slave: the fetch stage itself.
interface if_id_stage_if #(
  parameter int unsigned CNT_W = 16
);
  logic              pc_ld;
  logic              IF_ID_reg_ld;
  logic              flush;
  logic              is_jmp;
  logic [31:0]       imem_data;
  logic [31:0]       imem_addr;
  logic [31:0]       ID_inst;
  logic [31:0]       ID_pc4;
  logic              ID_valid;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output pc_ld, IF_ID_reg_ld, flush, is_jmp, imem_data,
    input  imem_addr, ID_inst, ID_pc4, ID_valid, stall_cnt, flush_cnt
  );

  modport slave (
    input  pc_ld, IF_ID_reg_ld, flush, is_jmp, imem_data,
    output imem_addr, ID_inst, ID_pc4, ID_valid, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/if_id_stage.sv
// MIPS instruction-fetch stage with IF/ID pipeline register and redirect logic.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module if_id_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input logic          clk,
  input logic          rst,
  if_id_stage_if.slave bus
);

  typedef enum logic {
    BUBBLE = 1'b0,
    VALID  = 1'b1
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt, pc4;
  logic [31:0] inst_q, inst_nxt;
  logic [31:0] pc4_q, pc4_nxt;
  logic [31:0] br_off, br_target, jmp_target;

  assign pc4        = pc + 32'd4;
  assign br_off     = {{14{inst_q[15]}}, inst_q[15:0], 2'b00};
  assign br_target  = pc4_q + br_off;
  assign jmp_target = {pc4_q[31:28], inst_q[25:0], 2'b00};

  // A stall (pc_ld=0) suppresses the redirect; the branch re-resolves next cycle.
  always_comb begin
    pc_nxt    = pc;
    state_nxt = state;
    inst_nxt  = inst_q;
    pc4_nxt   = pc4_q;
    if (bus.pc_ld) begin
      if (bus.flush) pc_nxt = bus.is_jmp ? jmp_target : br_target;
      else           pc_nxt = pc4;
    end
    if (bus.IF_ID_reg_ld) begin
      pc4_nxt = pc4;
      if (bus.flush) begin
        inst_nxt  = '0;
        state_nxt = BUBBLE;
      end else begin
        inst_nxt  = bus.imem_data;
        state_nxt = VALID;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc     <= RESET_PC;
      state  <= BUBBLE;
      inst_q <= '0;
      pc4_q  <= '0;
    end else begin
      pc     <= pc_nxt;
      state  <= state_nxt;
      inst_q <= inst_nxt;
      pc4_q  <= pc4_nxt;
    end
  end

  assign bus.imem_addr = pc;
  assign bus.ID_inst   = inst_q;
  assign bus.ID_pc4    = pc4_q;
  assign bus.ID_valid  = (state == VALID);

`ifdef IF_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!bus.pc_ld && stall_q != '1)                flush_q <= flush_q;
      if (!bus.pc_ld && stall_q != '1)                stall_q <= stall_q + CNT_W'(1);
      if (bus.pc_ld && bus.flush && flush_q != '1)    flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;
`else
  assign bus.stall_cnt = {CNT_W{1'b0}};
  assign bus.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: three instances (different RESET_PC / CNT_W)
// share stimulus; expectations are queued per DUT and checked by a monitor.
module tb_if_id_stage;

`ifdef IF_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pc_ld = 1'b0, if_id_ld = 1'b0, flush = 1'b0, is_jmp = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   stepno = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  if_id_stage_if #(.CNT_W(16)) bus_a ();
  if_id_stage_if #(.CNT_W(16)) bus_b ();
  if_id_stage_if #(.CNT_W(2))  bus_c ();

  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'd12:       mem = 32'h1000_FFFE;            // beq $0,$0,-2
      32'h1000_000C: mem = 32'h0800_0040;           // j 0x40
      default:      mem = 32'h2000_0000 | {16'h0, a[15:0]};
    endcase
  endfunction

  assign bus_a.pc_ld = pc_ld;  assign bus_a.IF_ID_reg_ld = if_id_ld;
  assign bus_a.flush = flush;  assign bus_a.is_jmp = is_jmp;
  assign bus_a.imem_data = mem(bus_a.imem_addr);
  assign bus_b.pc_ld = pc_ld;  assign bus_b.IF_ID_reg_ld = if_id_ld;
  assign bus_b.flush = flush;  assign bus_b.is_jmp = is_jmp;
  assign bus_b.imem_data = mem(bus_b.imem_addr);
  assign bus_c.pc_ld = pc_ld;  assign bus_c.IF_ID_reg_ld = if_id_ld;
  assign bus_c.flush = flush;  assign bus_c.is_jmp = is_jmp;
  assign bus_c.imem_data = mem(bus_c.imem_addr);

  if_id_stage #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  if_id_stage #(.RESET_PC(32'h1000_0008), .CNT_W(16)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  if_id_stage #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(2))  dut_c (.clk(clk), .rst(rst), .bus(bus_c));

  typedef struct {
    int          dut;
    int          due;
    int          step;
    logic [31:0] addr;
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        valid;
    int          sc;
    int          fc;
  } exp_t;

  exp_t sb[$];

  task automatic issue(input logic pl, input logic ld, input logic fl,
                       input logic jp, input logic r);
    @(posedge clk);
    #1;
    pc_ld = pl; if_id_ld = ld; flush = fl; is_jmp = jp; rst = r;
    stepno++;
  endtask

  task automatic expect_o(input int d, input logic [31:0] addr, input logic [31:0] inst,
                          input logic [31:0] pc4, input logic v, input int sc, input int fc);
    exp_t e;
    e.dut = d; e.due = cyc + 1; e.step = stepno;
    e.addr = addr; e.inst = inst; e.pc4 = pc4; e.valid = v;
    e.sc = PERF ? sc : 0;
    e.fc = PERF ? fc : 0;
    sb.push_back(e);
  endtask

  task automatic chk(input string nm, input int step, input int d,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step%0d dut%0d got %h exp %h", nm, step, d, act, exp);
    end
  endtask

  // Monitor: compares each queued expectation against the DUT after its due edge.
  initial begin
    exp_t e;
    logic [31:0] a_addr, a_inst, a_pc4, a_sc, a_fc;
    logic        a_v;
    forever begin
      @(posedge clk);
      #2;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        case (e.dut)
          0: begin a_addr = bus_a.imem_addr; a_inst = bus_a.ID_inst; a_pc4 = bus_a.ID_pc4;
                   a_v = bus_a.ID_valid; a_sc = 32'(bus_a.stall_cnt); a_fc = 32'(bus_a.flush_cnt); end
          1: begin a_addr = bus_b.imem_addr; a_inst = bus_b.ID_inst; a_pc4 = bus_b.ID_pc4;
                   a_v = bus_b.ID_valid; a_sc = 32'(bus_b.stall_cnt); a_fc = 32'(bus_b.flush_cnt); end
          default: begin a_addr = bus_c.imem_addr; a_inst = bus_c.ID_inst; a_pc4 = bus_c.ID_pc4;
                   a_v = bus_c.ID_valid; a_sc = 32'(bus_c.stall_cnt); a_fc = 32'(bus_c.flush_cnt); end
        endcase
        chk("imem_addr", e.step, e.dut, a_addr, e.addr);
        chk("ID_inst",   e.step, e.dut, a_inst, e.inst);
        chk("ID_pc4",    e.step, e.dut, a_pc4,  e.pc4);
        chk("ID_valid",  e.step, e.dut, {31'b0, a_v}, {31'b0, e.valid});
        chk("stall_cnt", e.step, e.dut, a_sc, e.sc);
        chk("flush_cnt", e.step, e.dut, a_fc, e.fc);
      end
    end
  end

  initial begin
    // reset state
    issue(0, 0, 0, 0, 0); expect_o(0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    // free run from PC 0
    issue(1, 1, 0, 0, 1); expect_o(0, 32'd4,  32'h2000_0000, 32'd4, 1, 0, 0);
    issue(1, 1, 0, 0, 1); expect_o(0, 32'd8,  32'h2000_0004, 32'd8, 1, 0, 0);
    // two-cycle stall at PC 8
    issue(0, 0, 0, 0, 1); expect_o(0, 32'd8,  32'h2000_0004, 32'd8, 1, 1, 0);
    issue(0, 0, 0, 0, 1); expect_o(0, 32'd8,  32'h2000_0004, 32'd8, 1, 2, 0);
    issue(1, 1, 0, 0, 1); expect_o(0, 32'd12, 32'h2000_0008, 32'd12, 1, 2, 0);
    issue(1, 1, 0, 0, 1); expect_o(0, 32'd16, 32'h1000_FFFE, 32'd16, 1, 2, 0);
    // taken branch: 16 + (-8) = 8
    issue(1, 1, 1, 0, 1); expect_o(0, 32'd8,  32'h0, 32'd20, 0, 2, 1);
    issue(1, 1, 0, 0, 1); expect_o(0, 32'd12, 32'h2000_0008, 32'd12, 1, 2, 1);
    issue(1, 1, 0, 0, 1); expect_o(0, 32'd16, 32'h1000_FFFE, 32'd16, 1, 2, 1);
    // flush under stall: nothing moves, no redirect counted
    issue(0, 0, 1, 0, 1); expect_o(0, 32'd16, 32'h1000_FFFE, 32'd16, 1, 3, 1);
    issue(1, 1, 1, 0, 1); expect_o(0, 32'd8,  32'h0, 32'd20, 0, 3, 2);
    // independent enables
    issue(1, 0, 0, 0, 1); expect_o(0, 32'd12, 32'h0, 32'd20, 0, 3, 2);
    issue(0, 1, 0, 0, 1); expect_o(0, 32'd12, 32'h1000_FFFE, 32'd16, 1, 4, 2);
    // reset during a stall wins; all three instances reset here
    issue(0, 0, 0, 0, 0);
    expect_o(0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    expect_o(1, 32'h1000_0008, 32'h0, 32'h0, 0, 0, 0);
    expect_o(2, 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 0, 0);
    // jump from 0x1000_000C (dut_b) and PC wrap (dut_c)
    issue(1, 1, 0, 0, 1);
    expect_o(1, 32'h1000_000C, 32'h2000_0008, 32'h1000_000C, 1, 0, 0);
    expect_o(2, 32'h0, 32'h2000_FFFC, 32'h0, 1, 0, 0);
    issue(1, 1, 0, 0, 1);
    expect_o(1, 32'h1000_0010, 32'h0800_0040, 32'h1000_0010, 1, 0, 0);
    expect_o(2, 32'd4, 32'h2000_0000, 32'd4, 1, 0, 0);
    issue(1, 1, 1, 1, 1);
    expect_o(1, 32'h1000_0100, 32'h0, 32'h1000_0014, 0, 0, 1);
    expect_o(2, 32'h0, 32'h0, 32'd8, 0, 0, 1);
    // long stall: dut_c's 2-bit stall counter saturates at 3
    for (int i = 1; i <= 4; i++) begin
      issue(0, 0, 0, 0, 1);
      expect_o(1, 32'h1000_0100, 32'h0, 32'h1000_0014, 0, i, 1);
      expect_o(2, 32'h0, 32'h0, 32'd8, 0, (i > 3) ? 3 : i, 1);
    end
    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got cycle %0d exp completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
